writeback_checker: RTL and testbench
====================================

# writeback_checker

Synthesizable self-checking sink for the pipelined MIPS core's write-back data stream. It holds a table of expected `writedata` values, compares each write-back strobe from the core against the next table entry in order, and reports pass, first mismatch, or timeout. It sits beside `pipemips` in the simulation top and on FPGA builds, replacing manual `$monitor` inspection of `writedata`.

## Interface
- `DEPTH`, 16: number of expected-value entries (power of two, ≥2).
- `DW`, 32: data width, matching the core's `writedata`.
- `TIMEOUT`, 64: consecutive RUN cycles without a strobe before giving up (≥2).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that arms a run.
- `exp_we`  in  1  expected-table write enable.
- `exp_addr`  in  $clog2(DEPTH)  table write address.
- `exp_data`  in  DW  table write data.
- `exp_count`  in  $clog2(DEPTH)+1  number of valid entries, sampled on `start`.
- `wb_valid`  in  1  core write-back strobe.
- `wb_data`  in  DW  core `writedata`.
- `state`  out  3  current state code.
- `done`  out  1  run finished (PASS, FAIL or TIMEOUT).
- `pass`  out  1  run finished in PASS.
- `fail_idx`  out  $clog2(DEPTH)  index of first mismatch.
- `fail_got`, `fail_exp`  out  DW  observed / expected value at mismatch.
- `cycle_count`  out  32  cycles spent in RUN, saturating.

## Operation
- States: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
- Reset (`rst`=0): state IDLE; `done`, `pass`, `fail_idx`, `fail_got`, `fail_exp`, `cycle_count`, internal index and timer all 0. Table contents are not reset.
- `exp_we` is honoured in IDLE, PASS, FAIL, TIMEOUT; ignored in RUN.
- `start` in any non-RUN state: latch `min(exp_count, DEPTH)` as count; clear index, timer, `cycle_count`, `done`, `pass`, fail fields. Count 0 → PASS; else → RUN. `start` in RUN is ignored.
- RUN, `wb_valid`=1: compare `wb_data` with table[index]. Mismatch → FAIL, capture index/got/exp. Match and index = count−1 → PASS. Match otherwise → index+1. Timer cleared on every strobe.
- RUN, `wb_valid`=0: timer+1; when timer = TIMEOUT−1 → TIMEOUT.
- Strobe on the cycle the timer would expire: strobe wins, no timeout.
- Terminal states are sticky; `wb_valid` ignored there; `done`=1, `pass`=1 only in PASS.
- `cycle_count` increments on every RUN cycle, saturates at 2^32−1, holds in terminal states.

## Timing
- All outputs registered; state transition and status update on the same rising edge that samples the deciding strobe; `done` visible the following cycle.
- Table write takes effect next edge; write and `start` on the same edge: `start` acts, write also completes (usable as entry for the run only if not index 0's first compare in that edge — i.e. always, since RUN begins next cycle).
- Table read is combinational from registered index; single-cycle compare, no back-pressure on the core.
- Reset assertion mid-run aborts immediately to IDLE with all outputs cleared.

## Structure
- Package `writeback_checker_pkg`: state encoding constants (3-bit codes above) and their typedef.
- Sub-module `exp_table`: DEPTH×DW register file, one synchronous write port, one asynchronous read port, no reset.
- Top holds FSM, index, timer, cycle counter and capture registers.

## Test plan
- Load {5, 10, 15}, count 3, start; strobe 5,10,15 with gaps of 3 idle cycles → PASS, `pass`=1, `cycle_count`=12.
- Load {5, 10, 15}; strobe 5, 11 → FAIL, `fail_idx`=1, `fail_got`=11, `fail_exp`=10; later strobes change nothing.
- TIMEOUT=8, count 2, strobe first entry then idle → TIMEOUT exactly 8 cycles after that strobe; strobe on the 8th idle cycle instead → stays RUN.
- count 0 → PASS next cycle; count 20 with DEPTH=16 → run checks exactly 16 entries.
- Assert `rst` mid-RUN after 2 of 3 matches → IDLE, all outputs 0; rerun with `start` and full sequence → PASS (table retained).
- `exp_we` to entry 0 during RUN → ignored; restart from PASS with `start` → re-runs same table, PASS again.

Source files
------------

// File: rtl/writeback_checker_pkg.sv
// Shared definitions for the write-back checker: the externally visible
// state codes and the saturation limit of the RUN cycle counter.
package writeback_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } wb_state_t;

    localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/writeback_checker_exp_table.sv
// Expected-value register file: one synchronous write port, one
// asynchronous read port, contents survive reset so a run can be repeated.
module exp_table #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/writeback_checker.sv
// Self-checking sink for the core's write-back stream: compares each strobe
// against the next expected entry and reports pass, first mismatch or timeout.
module writeback_checker
    import writeback_checker_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [DW-1:0]            exp_data,
    input  logic [$clog2(DEPTH):0]   exp_count,
    input  logic                     wb_valid,
    input  logic [DW-1:0]            wb_data,
    output logic [2:0]               state,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [DW-1:0]            fail_got,
    output logic [DW-1:0]            fail_exp,
    output logic [31:0]              cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    wb_state_t      st;
    logic [AW-1:0]  idx;
    logic [CW-1:0]  cnt;
    logic [TW-1:0]  timer;
    logic [DW-1:0]  exp_rd;
    logic [CW-1:0]  cnt_sel;
    logic           last_entry;

    // The table is frozen while a run is comparing against it.
    exp_table #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_table (
        .clk  (clk),
        .we   (exp_we && (st != ST_RUN)),
        .waddr(exp_addr),
        .wdata(exp_data),
        .raddr(idx),
        .rdata(exp_rd)
    );

    assign cnt_sel    = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
    assign last_entry = ({1'b0, idx} == (cnt - CW'(1)));
    assign state      = st;

    // A strobe is evaluated before the timer, so a strobe arriving on the
    // would-be expiry cycle keeps the run alive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            timer       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_idx    <= '0;
            fail_got    <= '0;
            fail_exp    <= '0;
            cycle_count <= '0;
        end else begin
            case (st)
                ST_RUN: begin
                    if (cycle_count != CYCLE_MAX) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    if (wb_valid) begin
                        timer <= '0;
                        if (wb_data != exp_rd) begin
                            st       <= ST_FAIL;
                            done     <= 1'b1;
                            fail_idx <= idx;
                            fail_got <= wb_data;
                            fail_exp <= exp_rd;
                        end else if (last_entry) begin
                            st   <= ST_PASS;
                            done <= 1'b1;
                            pass <= 1'b1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        st   <= ST_TIMEOUT;
                        done <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        cnt         <= cnt_sel;
                        idx         <= '0;
                        timer       <= '0;
                        cycle_count <= '0;
                        fail_idx    <= '0;
                        fail_got    <= '0;
                        fail_exp    <= '0;
                        if (cnt_sel == '0) begin
                            st   <= ST_PASS;
                            done <= 1'b1;
                            pass <= 1'b1;
                        end else begin
                            st   <= ST_RUN;
                            done <= 1'b0;
                            pass <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_checker.sv
// Directed bench for writeback_checker with TIMEOUT shortened to 8 cycles.
module tb_writeback_checker;

    localparam int DEPTH   = 16;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          exp_we = 1'b0;
    logic [3:0]    exp_addr = '0;
    logic [31:0]   exp_data = '0;
    logic [4:0]    exp_count = '0;
    logic          wb_valid = 1'b0;
    logic [31:0]   wb_data = '0;
    logic [2:0]    state;
    logic          done;
    logic          pass;
    logic [3:0]    fail_idx;
    logic [31:0]   fail_got;
    logic [31:0]   fail_exp;
    logic [31:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    writeback_checker #(
        .DEPTH  (DEPTH),
        .DW     (DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .exp_we     (exp_we),
        .exp_addr   (exp_addr),
        .exp_data   (exp_data),
        .exp_count  (exp_count),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .state      (state),
        .done       (done),
        .pass       (pass),
        .fail_idx   (fail_idx),
        .fail_got   (fail_got),
        .fail_exp   (fail_exp),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadEntry(input logic [3:0] addr, input logic [31:0] data);
        exp_we   = 1'b1;
        exp_addr = addr;
        exp_data = data;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic startRun(input logic [4:0] cnt);
        start     = 1'b1;
        exp_count = cnt;
        tick();
        start     = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] data);
        wb_valid = 1'b1;
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus();
        loadEntry(4'd0, 32'd5);
        loadEntry(4'd1, 32'd10);
        loadEntry(4'd2, 32'd15);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle(2);
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset pass", 32'(pass), 32'd0);
        checkOutput("reset cycle_count", cycle_count, 32'd0);
        rst = 1'b1;
        idle(1);

        // Basic pass with 3-cycle gaps
        applyStimulus();
        startRun(5'd3);
        checkOutput("pass run state", 32'(state), 32'd1);
        idle(3); strobe(32'd5);
        idle(3); strobe(32'd10);
        checkOutput("pass mid state", 32'(state), 32'd1);
        checkOutput("pass mid done", 32'(done), 32'd0);
        idle(3); strobe(32'd15);
        checkOutput("pass state", 32'(state), 32'd2);
        checkOutput("pass done", 32'(done), 32'd1);
        checkOutput("pass flag", 32'(pass), 32'd1);
        checkOutput("pass cycle_count", cycle_count, 32'd12);

        // Table write during RUN is ignored; restart from PASS
        startRun(5'd3);
        checkOutput("restart done cleared", 32'(done), 32'd0);
        checkOutput("restart cycle_count cleared", cycle_count, 32'd0);
        loadEntry(4'd0, 32'd99);
        strobe(32'd5); strobe(32'd10); strobe(32'd15);
        checkOutput("we in run ignored state", 32'(state), 32'd2);
        checkOutput("we in run ignored pass", 32'(pass), 32'd1);
        checkOutput("we in run cycle_count", cycle_count, 32'd4);

        // First mismatch at index 1, then sticky
        startRun(5'd3);
        strobe(32'd5); strobe(32'd11);
        checkOutput("fail state", 32'(state), 32'd3);
        checkOutput("fail done", 32'(done), 32'd1);
        checkOutput("fail pass", 32'(pass), 32'd0);
        checkOutput("fail idx", 32'(fail_idx), 32'd1);
        checkOutput("fail got", fail_got, 32'd11);
        checkOutput("fail exp", fail_exp, 32'd10);
        strobe(32'd10); strobe(32'd77); idle(10);
        checkOutput("fail sticky state", 32'(state), 32'd3);
        checkOutput("fail sticky got", fail_got, 32'd11);
        checkOutput("fail sticky cycle_count", cycle_count, 32'd2);

        // Timeout exactly TIMEOUT idle cycles after a strobe
        startRun(5'd2);
        checkOutput("restart fail fields cleared", fail_got, 32'd0);
        strobe(32'd5);
        idle(7);
        checkOutput("timeout pending state", 32'(state), 32'd1);
        idle(1);
        checkOutput("timeout state", 32'(state), 32'd4);
        checkOutput("timeout done", 32'(done), 32'd1);
        checkOutput("timeout pass", 32'(pass), 32'd0);
        checkOutput("timeout cycle_count", cycle_count, 32'd9);

        // Strobe on the expiry cycle wins
        startRun(5'd3);
        strobe(32'd5);
        idle(7);
        strobe(32'd10);
        checkOutput("strobe beats timeout", 32'(state), 32'd1);
        idle(1);
        checkOutput("timer cleared by strobe", 32'(state), 32'd1);
        strobe(32'd15);
        checkOutput("late pass state", 32'(state), 32'd2);

        // Empty run passes immediately
        startRun(5'd0);
        checkOutput("count0 state", 32'(state), 32'd2);
        checkOutput("count0 pass", 32'(pass), 32'd1);
        checkOutput("count0 cycle_count", cycle_count, 32'd0);

        // Count above DEPTH is clamped to DEPTH
        for (int i = 0; i < DEPTH; i++) loadEntry(4'(i), 32'(i * 3 + 100));
        startRun(5'd20);
        for (int i = 0; i < DEPTH - 1; i++) strobe(32'(i * 3 + 100));
        checkOutput("clamp before last", 32'(state), 32'd1);
        strobe(32'(15 * 3 + 100));
        checkOutput("clamp state", 32'(state), 32'd2);
        checkOutput("clamp cycle_count", cycle_count, 32'd16);

        // Asynchronous reset mid-run, table retained afterwards
        applyStimulus();
        startRun(5'd3);
        strobe(32'd5); strobe(32'd10);
        rst = 1'b0;
        #2;
        checkOutput("midrun reset state", 32'(state), 32'd0);
        checkOutput("midrun reset done", 32'(done), 32'd0);
        checkOutput("midrun reset cycle_count", cycle_count, 32'd0);
        tick();
        rst = 1'b1;
        idle(1);
        startRun(5'd3);
        strobe(32'd5); strobe(32'd10); strobe(32'd15);
        checkOutput("post reset pass state", 32'(state), 32'd2);
        checkOutput("post reset pass flag", 32'(pass), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
